// File: rtl/handshake_const_match_sink.sv
// handshake_const_match_sink
//   Receiving end of a constant-token channel. Each accepted data token is
//   compared against the constant EXPECTED. The 1-bit result goes into a
//   2-entry elastic buffer and is returned as a dataless control token that
//   carries the match flag. The block also keeps two debug counters:
//   a wrapping count of accepted tokens and a saturating count of mismatches.
//
// Ports
//   clk             clock, all state updates on rising edge
//   rst             asynchronous reset, active low
//   ins             incoming data token
//   ins_valid       ins carries a token
//   ins_ready       block accepts a token this cycle
//   outs_match      match flag of the head control token (0 when empty)
//   outs_valid      control token available
//   outs_ready      consumer accepts the token
//   mismatch_count  saturating count of accepted mismatching tokens
//   token_count     wrapping count of accepted tokens
//
// Buffer occupancy FSM
//   state   | meaning
//   S_EMPTY | no control token buffered
//   S_ONE   | one token buffered, held in r_head
//   S_TWO   | two tokens buffered, r_head is oldest, r_tail is newest
module handshake_const_match_sink #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned EXPECTED   = 7,
  parameter int unsigned CNT_WIDTH  = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] ins,
  input  logic                  ins_valid,
  output logic                  ins_ready,
  output logic                  outs_match,
  output logic                  outs_valid,
  input  logic                  outs_ready,
  output logic [CNT_WIDTH-1:0]  mismatch_count,
  output logic [CNT_WIDTH-1:0]  token_count
);

  // Unsigned cast: truncates or zero-extends EXPECTED to the token width.
  localparam logic [DATA_WIDTH-1:0] EXP_W = DATA_WIDTH'(EXPECTED);

  typedef enum logic [1:0] {
    S_EMPTY = 2'd0,
    S_ONE   = 2'd1,
    S_TWO   = 2'd2
  } state_t;

  state_t               r_state;
  state_t               w_state_nxt;
  logic                 r_head;
  logic                 r_tail;
  logic                 w_head_nxt;
  logic                 w_tail_nxt;
  logic [CNT_WIDTH-1:0] r_token_count;
  logic [CNT_WIDTH-1:0] r_mismatch_count;

  logic w_push;
  logic w_pop;
  logic w_match;

  // ins_ready depends only on registered occupancy and the reset pin, never
  // on outs_ready; a full buffer simply refuses the token.
  assign ins_ready  = rst & (r_state != S_TWO);
  assign outs_valid = (r_state != S_EMPTY);
  assign outs_match = outs_valid & r_head;

  assign w_push  = ins_valid & ins_ready;
  assign w_pop   = outs_valid & outs_ready;
  assign w_match = (ins == EXP_W);

  always_comb begin
    w_state_nxt = r_state;
    w_head_nxt  = r_head;
    w_tail_nxt  = r_tail;
    case (r_state)
      S_EMPTY: begin
        if (w_push) begin
          w_state_nxt = S_ONE;
          w_head_nxt  = w_match;
        end
      end
      S_ONE: begin
        if (w_push && w_pop) begin
          // Head leaves while the new token arrives: new token becomes head.
          w_head_nxt = w_match;
        end else if (w_push) begin
          w_state_nxt = S_TWO;
          w_tail_nxt  = w_match;
        end else if (w_pop) begin
          w_state_nxt = S_EMPTY;
          w_head_nxt  = 1'b0;
        end
      end
      S_TWO: begin
        if (w_pop) begin
          w_state_nxt = S_ONE;
          w_head_nxt  = r_tail;
          w_tail_nxt  = 1'b0;
        end
      end
      default: begin
        w_state_nxt = S_EMPTY;
        w_head_nxt  = 1'b0;
        w_tail_nxt  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state <= S_EMPTY;
      r_head  <= 1'b0;
      r_tail  <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_head  <= w_head_nxt;
      r_tail  <= w_tail_nxt;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_token_count    <= '0;
      r_mismatch_count <= '0;
    end else if (w_push) begin
      r_token_count <= r_token_count + CNT_WIDTH'(1);
      if (!w_match && (r_mismatch_count != '1)) begin
        r_mismatch_count <= r_mismatch_count + CNT_WIDTH'(1);
      end
    end
  end

  assign token_count    = r_token_count;
  assign mismatch_count = r_mismatch_count;

endmodule

// File: tb/tb_handshake_const_match_sink.sv
module tb_handshake_const_match_sink;

  logic        clk;
  logic        rst;
  logic [31:0] ins;
  logic        ins_valid;
  logic        ins_ready;
  logic        outs_match;
  logic        outs_valid;
  logic        outs_ready;
  logic [15:0] mismatch_count;
  logic [15:0] token_count;

  logic [31:0] ins4;
  logic        ins_valid4;
  logic        ins_ready4;
  logic        outs_match4;
  logic        outs_valid4;
  logic        outs_ready4;
  logic [3:0]  mismatch_count4;
  logic [3:0]  token_count4;

  int checks   = 0;
  int failures = 0;
  int n_pops   = 0;
  bit sb[$];

  handshake_const_match_sink #(
    .DATA_WIDTH(32), .EXPECTED(7), .CNT_WIDTH(16)
  ) u_dut (
    .clk(clk), .rst(rst), .ins(ins), .ins_valid(ins_valid),
    .ins_ready(ins_ready), .outs_match(outs_match), .outs_valid(outs_valid),
    .outs_ready(outs_ready), .mismatch_count(mismatch_count),
    .token_count(token_count)
  );

  handshake_const_match_sink #(
    .DATA_WIDTH(32), .EXPECTED(7), .CNT_WIDTH(4)
  ) u_dut4 (
    .clk(clk), .rst(rst), .ins(ins4), .ins_valid(ins_valid4),
    .ins_ready(ins_ready4), .outs_match(outs_match4), .outs_valid(outs_valid4),
    .outs_ready(outs_ready4), .mismatch_count(mismatch_count4),
    .token_count(token_count4)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Scoreboard: sampled at the falling edge, the values seen there decide the
  // transfers of the next rising edge. Pop before push: a token pushed now
  // cannot be delivered until the following cycle.
  always @(negedge clk) begin
    if (rst) begin
      if (outs_valid && outs_ready) begin
        checks++;
        n_pops++;
        if (sb.size() == 0) begin
          failures++;
          $display("FAIL sb_underflow: outs_valid with no expected token, outs_match=%0b", outs_match);
        end else begin
          bit e;
          e = sb.pop_front();
          if (outs_match !== e) begin
            failures++;
            $display("FAIL sb_match: got %0b expected %0b", outs_match, e);
          end
        end
      end
      if (ins_valid && ins_ready) sb.push_back(ins == 32'd7);
    end
  end

  // Reset discards buffered tokens.
  always @(negedge rst) sb.delete();

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, checks=%0d", checks);
    $fatal(1, "timeout");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    cyc();
    rst = 1'b0;
    ins_valid = 1'b0;
    ins_valid4 = 1'b0;
    outs_ready = 1'b0;
    cyc();
    cyc();
    rst = 1'b1;
  endtask

  task automatic test_reset();
    for (int i = 0; i < 3; i++) begin
      cyc();
      @(negedge clk);
      checks++;
      if (ins_ready !== 1'b0 || outs_valid !== 1'b0 || outs_match !== 1'b0) begin
        failures++;
        $display("FAIL reset_hold: ready=%0b valid=%0b match=%0b expected 0 0 0", ins_ready, outs_valid, outs_match);
      end
      checks++;
      if (mismatch_count !== 16'd0 || token_count !== 16'd0) begin
        failures++;
        $display("FAIL reset_counts: mism=%0d tok=%0d expected 0 0", mismatch_count, token_count);
      end
    end
    cyc();
    rst = 1'b1;
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_ready: got %0b expected 1", ins_ready);
    end
    cyc();
    ins_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b1 || outs_match !== 1'b1) begin
      failures++;
      $display("FAIL reset_first_out: valid=%0b match=%0b expected 1 1", outs_valid, outs_match);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b0 || token_count !== 16'd1) begin
      failures++;
      $display("FAIL reset_drain: valid=%0b tok=%0d expected 0 1", outs_valid, token_count);
    end
  endtask

  task automatic test_streaming();
    logic [31:0] vals [5] = '{32'd7, 32'd7, 32'd3, 32'd7, 32'd0};
    bit          exps [5] = '{1'b1, 1'b1, 1'b0, 1'b1, 1'b0};
    do_reset();
    outs_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      cyc();
      ins = vals[i];
      ins_valid = 1'b1;
      @(negedge clk);
      checks++;
      if (ins_ready !== 1'b1) begin
        failures++;
        $display("FAIL stream_ready[%0d]: got %0b expected 1", i, ins_ready);
      end
      if (i > 0) begin
        checks++;
        if (outs_valid !== 1'b1 || outs_match !== exps[i-1]) begin
          failures++;
          $display("FAIL stream_out[%0d]: valid=%0b match=%0b expected 1 %0b", i-1, outs_valid, outs_match, exps[i-1]);
        end
      end
    end
    cyc();
    ins_valid = 1'b0;
    ins = 'x;
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b1 || outs_match !== exps[4]) begin
      failures++;
      $display("FAIL stream_out[4]: valid=%0b match=%0b expected 1 %0b", outs_valid, outs_match, exps[4]);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b0 || mismatch_count !== 16'd2 || token_count !== 16'd5) begin
      failures++;
      $display("FAIL stream_counts: valid=%0b mism=%0d tok=%0d expected 0 2 5", outs_valid, mismatch_count, token_count);
    end
  endtask

  task automatic test_backpressure();
    int pops0;
    do_reset();
    pops0 = n_pops;
    cyc();
    ins = 32'd7;
    ins_valid = 1'b1;
    @(negedge clk);
    cyc();
    ins = 32'd5;
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b1 || outs_valid !== 1'b1 || outs_match !== 1'b1) begin
      failures++;
      $display("FAIL bp_one: ready=%0b valid=%0b match=%0b expected 1 1 1", ins_ready, outs_valid, outs_match);
    end
    cyc();
    ins_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b0 || outs_match !== 1'b1) begin
      failures++;
      $display("FAIL bp_full: ready=%0b match=%0b expected 0 1", ins_ready, outs_match);
    end
    cyc();
    outs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b0) begin
      failures++;
      $display("FAIL bp_ready_before_pop: got %0b expected 0", ins_ready);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (ins_ready !== 1'b1 || outs_valid !== 1'b1 || outs_match !== 1'b0) begin
      failures++;
      $display("FAIL bp_second: ready=%0b valid=%0b match=%0b expected 1 1 0", ins_ready, outs_valid, outs_match);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b0 || (n_pops - pops0) != 2) begin
      failures++;
      $display("FAIL bp_drain: valid=%0b pops=%0d expected 0 2", outs_valid, n_pops - pops0);
    end
  endtask

  task automatic test_push_pop_one();
    do_reset();
    cyc();
    ins = 32'd7;
    ins_valid = 1'b1;
    @(negedge clk);
    cyc();
    ins = 32'd9;
    outs_ready = 1'b1;
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b1 || outs_match !== 1'b1 || ins_ready !== 1'b1) begin
      failures++;
      $display("FAIL pp_before: valid=%0b match=%0b ready=%0b expected 1 1 1", outs_valid, outs_match, ins_ready);
    end
    cyc();
    ins_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b1 || outs_match !== 1'b0 || ins_ready !== 1'b1) begin
      failures++;
      $display("FAIL pp_after: valid=%0b match=%0b ready=%0b expected 1 0 1", outs_valid, outs_match, ins_ready);
    end
    cyc();
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b0) begin
      failures++;
      $display("FAIL pp_drain: valid=%0b expected 0", outs_valid);
    end
  endtask

  task automatic test_saturation();
    do_reset();
    outs_ready4 = 1'b1;
    ins4 = 32'd1;
    for (int i = 0; i < 20; i++) begin
      cyc();
      ins_valid4 = 1'b1;
      @(negedge clk);
      if (i == 15) begin
        checks++;
        if (mismatch_count4 !== 4'd15 || token_count4 !== 4'd15) begin
          failures++;
          $display("FAIL sat_at15: mism=%0d tok=%0d expected 15 15", mismatch_count4, token_count4);
        end
      end
      if (i == 16) begin
        checks++;
        if (mismatch_count4 !== 4'd15 || token_count4 !== 4'd0) begin
          failures++;
          $display("FAIL sat_wrap: mism=%0d tok=%0d expected 15 0", mismatch_count4, token_count4);
        end
      end
    end
    cyc();
    ins_valid4 = 1'b0;
    @(negedge clk);
    checks++;
    if (mismatch_count4 !== 4'd15 || token_count4 !== 4'd4 || outs_match4 !== 1'b0) begin
      failures++;
      $display("FAIL sat_final: mism=%0d tok=%0d match=%0b expected 15 4 0", mismatch_count4, token_count4, outs_match4);
    end
  endtask

  task automatic test_reset_mid();
    do_reset();
    cyc();
    ins = 32'd7;
    ins_valid = 1'b1;
    cyc();
    ins = 32'd3;
    cyc();
    ins_valid = 1'b0;
    @(negedge clk);
    checks++;
    if (outs_valid !== 1'b1 || ins_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_full: valid=%0b ready=%0b expected 1 0", outs_valid, ins_ready);
    end
    @(posedge clk);
    #2;
    rst = 1'b0;
    #1;
    checks++;
    if (outs_valid !== 1'b0 || outs_match !== 1'b0 || ins_ready !== 1'b0) begin
      failures++;
      $display("FAIL rm_async: valid=%0b match=%0b ready=%0b expected 0 0 0", outs_valid, outs_match, ins_ready);
    end
    #1;
    rst = 1'b1;
    outs_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      checks++;
      if (outs_valid !== 1'b0 || token_count !== 16'd0 || ins_ready !== 1'b1) begin
        failures++;
        $display("FAIL rm_stale[%0d]: valid=%0b tok=%0d ready=%0b expected 0 0 1", i, outs_valid, token_count, ins_ready);
      end
      cyc();
    end
  endtask

  initial begin
    rst = 1'b0;
    ins = 32'd7;
    ins_valid = 1'b1;
    outs_ready = 1'b1;
    ins4 = 32'd0;
    ins_valid4 = 1'b0;
    outs_ready4 = 1'b1;

    test_reset();
    test_streaming();
    test_backpressure();
    test_push_pop_one();
    test_saturation();
    test_reset_mid();

    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL sb_leftover: %0d tokens never delivered, expected 0", sb.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
